// File: rtl/spi_memory_fsm_if.sv
// Handshake bundle between the SPI memory transaction controller and its datapath.
// The master side drives the conditioned SPI inputs; the slave side is the controller.
interface spi_memory_fsm_if;
    logic       cs;
    logic       sclk_posedge;
    logic       sr_pout0;
    logic       addr_we;
    logic       sr_we;
    logic       dm_we;
    logic       miso_buff_en;
    logic [3:0] state;

    modport master (
        output cs,
        output sclk_posedge,
        output sr_pout0,
        input  addr_we,
        input  sr_we,
        input  dm_we,
        input  miso_buff_en,
        input  state
    );

    modport slave (
        input  cs,
        input  sclk_posedge,
        input  sr_pout0,
        output addr_we,
        output sr_we,
        output dm_we,
        output miso_buff_en,
        output state
    );
endinterface

// File: rtl/spi_memory_fsm.sv
// SPI memory transaction controller: frames 7 address bits, an R/W bit and 8 data bits,
// and sequences the address latch, shift-register load, memory write and MISO enable.
module spi_memory_fsm (
    input logic             clk,
    input logic             reset,
    spi_memory_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StGetAddr   = 4'd1,
        StDecode    = 4'd2,
        StReadWait  = 4'd3,
        StReadLoad  = 4'd4,
        StReadSend  = 4'd5,
        StWriteRecv = 4'd6,
        StWriteMem  = 4'd7,
        StDone      = 4'd8
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] bit_count_q, bit_count_d;
    logic       addr_we_q, sr_we_q, dm_we_q, miso_buff_en_q;
    logic       last_edge;

    assign last_edge = bus.sclk_posedge && (bit_count_q == 4'd7);

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        case (state_q)
            StIdle: begin
                bit_count_d = 4'd0;
                if (!bus.cs) state_d = StGetAddr;
            end
            StGetAddr: begin
                if (bus.sclk_posedge) bit_count_d = bit_count_q + 4'd1;
                if (last_edge) state_d = StDecode;
            end
            StDecode: begin
                bit_count_d = 4'd0;
                state_d     = bus.sr_pout0 ? StReadWait : StWriteRecv;
            end
            StReadWait: state_d = StReadLoad;
            StReadLoad: begin
                bit_count_d = 4'd0;
                state_d     = StReadSend;
            end
            StReadSend: begin
                if (bus.sclk_posedge) bit_count_d = bit_count_q + 4'd1;
                if (last_edge) state_d = StDone;
            end
            StWriteRecv: begin
                if (bus.sclk_posedge) bit_count_d = bit_count_q + 4'd1;
                if (last_edge) state_d = StWriteMem;
            end
            StWriteMem: state_d = StDone;
            StDone:     state_d = StDone;
            default: begin
                state_d     = StIdle;
                bit_count_d = 4'd0;
            end
        endcase
        // Chip-select release aborts any frame and wins over a coincident SCLK edge.
        if (state_q != StIdle && bus.cs) begin
            state_d     = StIdle;
            bit_count_d = 4'd0;
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            bit_count_q     <= 4'd0;
            addr_we_q       <= 1'b0;
            sr_we_q         <= 1'b0;
            dm_we_q         <= 1'b0;
            miso_buff_en_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_count_q     <= bit_count_d;
            addr_we_q       <= (state_d == StDecode);
            sr_we_q         <= (state_d == StReadLoad);
            dm_we_q         <= (state_d == StWriteMem);
            miso_buff_en_q  <= (state_d == StReadSend);
        end
    end

    assign bus.addr_we      = addr_we_q;
    assign bus.sr_we        = sr_we_q;
    assign bus.dm_we        = dm_we_q;
    assign bus.miso_buff_en = miso_buff_en_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Directed bench for spi_memory_fsm: every cycle's expected state and strobes are queued
// with the stimulus and compared one clock later.
module tb_spi_memory_fsm;

    localparam logic [3:0] Idle      = 4'd0;
    localparam logic [3:0] GetAddr   = 4'd1;
    localparam logic [3:0] Decode    = 4'd2;
    localparam logic [3:0] ReadWait  = 4'd3;
    localparam logic [3:0] ReadLoad  = 4'd4;
    localparam logic [3:0] ReadSend  = 4'd5;
    localparam logic [3:0] WriteRecv = 4'd6;
    localparam logic [3:0] WriteMem  = 4'd7;
    localparam logic [3:0] Done      = 4'd8;

    // {addr_we, sr_we, dm_we, miso_buff_en}
    localparam logic [3:0] OutNone = 4'b0000;
    localparam logic [3:0] OutAw   = 4'b1000;
    localparam logic [3:0] OutSr   = 4'b0100;
    localparam logic [3:0] OutDm   = 4'b0010;
    localparam logic [3:0] OutMiso = 4'b0001;

    typedef struct {
        string      tag;
        logic [7:0] vec;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] sr_model;
    exp_t       exp_q[$];
    int         checks;
    int         errors;

    spi_memory_fsm_if bus ();

    spi_memory_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.sr_pout0 = sr_model[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic r, input logic c, input logic sp, input logic mosi,
                        input logic [3:0] es, input logic [3:0] eo, input string tag);
        exp_t e;
        logic [7:0] obs;
        reset            = r;
        bus.cs           = c;
        bus.sclk_posedge = sp;
        e.tag = tag;
        e.vec = {es, eo};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (sp) sr_model = {sr_model[6:0], mosi};
        e   = exp_q.pop_front();
        obs = {bus.state, bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff_en};
        checks++;
        assert (obs === e.vec) else begin
            errors++;
            $error("FAIL %s: state/aw/sr/dm/miso observed %h_%b required %h_%b",
                   e.tag, obs[7:4], obs[3:0], e.vec[7:4], e.vec[3:0]);
        end
    endtask

    task automatic run(input logic c, input int n, input logic [3:0] es,
                       input logic [3:0] eo, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, c, 1'b0, 1'b0, es, eo, tag);
    endtask

    // One SCLK edge followed by four idle clocks, all expected to hold es/eo.
    task automatic sbit(input logic mosi, input logic [3:0] es, input logic [3:0] eo,
                        input string tag);
        tick(1'b0, 1'b0, 1'b1, mosi, es, eo, tag);
        run(1'b0, 4, es, eo, tag);
    endtask

    task automatic start_frame();
        run(1'b1, 2, Idle, OutNone, "idle_cs_high");
        tick(1'b0, 1'b0, 1'b0, 1'b0, GetAddr, OutNone, "cs_fall");
        run(1'b0, 3, GetAddr, OutNone, "get_addr_wait");
    endtask

    task automatic addr_phase(input logic [6:0] addr, input logic rw);
        for (int i = 0; i < 7; i++) sbit(addr[6-i], GetAddr, OutNone, "addr_bit");
        tick(1'b0, 1'b0, 1'b1, rw, Decode, OutAw, "addr_we_n1");
    endtask

    task automatic write_frame(input logic [6:0] addr, input logic [7:0] data,
                               input int extra);
        start_frame();
        addr_phase(addr, 1'b0);
        run(1'b0, 4, WriteRecv, OutNone, "write_recv");
        for (int i = 0; i < 7; i++) sbit(data[7-i], WriteRecv, OutNone, "data_bit");
        tick(1'b0, 1'b0, 1'b1, data[0], WriteMem, OutDm, "dm_we");
        run(1'b0, 4, Done, OutNone, "write_done");
        for (int i = 0; i < extra; i++) sbit(1'b1, Done, OutNone, "done_extra_edge");
        tick(1'b0, 1'b1, 1'b0, 1'b0, Idle, OutNone, "cs_rise");
    endtask

    task automatic read_frame(input logic [6:0] addr, input logic inject);
        start_frame();
        addr_phase(addr, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, ReadWait, OutNone, "read_wait_n2");
        tick(1'b0, 1'b0, inject, 1'b1, ReadLoad, OutSr, "sr_we_n3");
        tick(1'b0, 1'b0, 1'b0, 1'b0, ReadSend, OutMiso, "miso_n4");
        run(1'b0, 1, ReadSend, OutMiso, "read_send_gap");
        for (int i = 0; i < 7; i++) sbit(1'b0, ReadSend, OutMiso, "send_bit");
        tick(1'b0, 1'b0, 1'b1, 1'b0, Done, OutNone, "read_done");
        run(1'b0, 3, Done, OutNone, "read_done_hold");
        tick(1'b0, 1'b1, 1'b0, 1'b0, Idle, OutNone, "cs_rise_read");
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        sr_model         = 8'h00;
        reset            = 1'b1;
        bus.cs           = 1'b1;
        bus.sclk_posedge = 1'b0;

        tick(1'b1, 1'b1, 1'b0, 1'b0, Idle, OutNone, "reset");
        tick(1'b1, 1'b0, 1'b1, 1'b0, Idle, OutNone, "reset_overrides");
        run(1'b1, 2, Idle, OutNone, "idle_cs_high");

        // Write 0xC3 to 0x2A, then extra SCLK edges and a long cs-low stay in DONE.
        write_frame(7'h2A, 8'hC3, 3);

        // Plain read of 0x2A.
        read_frame(7'h2A, 1'b0);

        // Abort after five data bits: no dm_we, then a full write works.
        start_frame();
        addr_phase(7'h15, 1'b0);
        run(1'b0, 4, WriteRecv, OutNone, "write_recv");
        for (int i = 0; i < 5; i++) sbit(1'b1, WriteRecv, OutNone, "data_bit_pre_abort");
        tick(1'b0, 1'b1, 1'b0, 1'b0, Idle, OutNone, "abort_write");
        run(1'b1, 2, Idle, OutNone, "abort_idle");
        write_frame(7'h55, 8'h3C, 0);

        // Reset in READ_SEND with cs held low, then release into GET_ADDR.
        start_frame();
        addr_phase(7'h2A, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, ReadWait, OutNone, "read_wait_n2");
        tick(1'b0, 1'b0, 1'b0, 1'b0, ReadLoad, OutSr, "sr_we_n3");
        tick(1'b0, 1'b0, 1'b0, 1'b0, ReadSend, OutMiso, "miso_n4");
        run(1'b0, 1, ReadSend, OutMiso, "read_send_gap");
        for (int i = 0; i < 3; i++) sbit(1'b0, ReadSend, OutMiso, "send_bit");
        tick(1'b1, 1'b0, 1'b0, 1'b0, Idle, OutNone, "reset_mid_read");
        tick(1'b1, 1'b0, 1'b1, 1'b0, Idle, OutNone, "reset_hold_cs_low");
        tick(1'b0, 1'b0, 1'b0, 1'b0, GetAddr, OutNone, "reset_release");
        tick(1'b0, 1'b1, 1'b0, 1'b0, Idle, OutNone, "abort_get_addr");

        // SCLK edge coincident with cs release in GET_ADDR, then a full frame.
        start_frame();
        for (int i = 0; i < 3; i++) sbit(1'b1, GetAddr, OutNone, "addr_bit");
        tick(1'b0, 1'b1, 1'b1, 1'b1, Idle, OutNone, "collision");
        write_frame(7'h7F, 8'hA5, 1);

        // Stray SCLK edge in READ_WAIT must not count toward the eight data edges.
        read_frame(7'h01, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
